// File: rtl/pwm_capture.sv
// Servo-style PWM pulse-width capture: measures high time in ticks, reports it with a
// one-cycle strobe, and flags loss of signal after a period with no line activity.
//
// state  | meaning
// IDLE   | waiting to see the line low before trusting any rising edge
// ARMED  | line low, waiting for a rising edge
// HIGH   | measuring a high pulse
module pwm_capture #(
    parameter int TICK_CYCLES    = 100,
    parameter int MIN_TICKS      = 8,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pwm_in,
    output logic [9:0] duty_out,
    output logic       duty_valid,
    output logic       duty_sat,
    output logic       signal_lost
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WW = 11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_HIGH  = 2'd2;

    logic          sync_1;
    logic          sync_2;
    logic          hist;
    logic [1:0]    state;
    logic [PW-1:0] presc;
    logic [WW-1:0] width;
    logic [WW-1:0] width_cap;
    logic [TW-1:0] tmo_cnt;
    logic          accept_q;

    logic          rise;
    logic          fall;
    logic          presc_wrap;
    logic [WW-1:0] width_next;
    logic          tmo_hit;

    always_comb begin
        rise       = sync_2 & ~hist;
        fall       = ~sync_2 & hist;
        presc_wrap = (presc == PW'(TICK_CYCLES - 1));
        width_next = width;
        if (presc_wrap && (width != {WW{1'b1}}))
            width_next = width + 1'b1;
        // A falling edge in the same cycle as the timeout wins.
        tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES)) && !((state == ST_HIGH) && fall);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_1      <= 1'b1;
            sync_2      <= 1'b1;
            hist        <= 1'b1;
            state       <= ST_IDLE;
            presc       <= '0;
            width       <= '0;
            width_cap   <= '0;
            tmo_cnt     <= '0;
            accept_q    <= 1'b0;
            duty_out    <= '0;
            duty_valid  <= 1'b0;
            duty_sat    <= 1'b0;
            signal_lost <= 1'b1;
        end else begin
            sync_1     <= pwm_in;
            sync_2     <= sync_1;
            hist       <= sync_2;
            duty_valid <= 1'b0;
            accept_q   <= 1'b0;

            if (rise || fall)
                tmo_cnt <= '0;
            else if (tmo_cnt != TW'(TIMEOUT_CYCLES))
                tmo_cnt <= tmo_cnt + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (!sync_2)
                        state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (rise) begin
                        state <= ST_HIGH;
                        presc <= '0;
                        width <= '0;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        state <= ST_ARMED;
                        // width_next counts the current cycle too, so width = floor(high/TICK).
                        if (width_next >= WW'(MIN_TICKS)) begin
                            accept_q  <= 1'b1;
                            width_cap <= width_next;
                        end
                    end else if (tmo_hit) begin
                        state <= ST_IDLE;
                    end else begin
                        presc <= presc_wrap ? '0 : presc + 1'b1;
                        width <= width_next;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Extra pipeline stage places the strobe three edges after the sampled fall.
            if (accept_q) begin
                duty_out    <= (width_cap > 11'd1023) ? 10'd1023 : width_cap[9:0];
                duty_sat    <= (width_cap > 11'd1023);
                duty_valid  <= 1'b1;
                signal_lost <= 1'b0;
            end else if (tmo_hit) begin
                signal_lost <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with scaled-down timing parameters
// (TICK_CYCLES=4, TIMEOUT_CYCLES=8000) so every scenario fits a short run.
module tb_pwm_capture;

    localparam int TICK    = 4;
    localparam int MIN_T   = 8;
    localparam int TIMEOUT = 8000;

    logic       clock = 1'b0;
    logic       reset;
    logic       pwm_in;
    logic [9:0] duty_out;
    logic       duty_valid;
    logic       duty_sat;
    logic       signal_lost;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int strobe_cnt = 0;
    int last_strobe_cyc = -1;
    int fall_cyc = 0;

    pwm_capture #(
        .TICK_CYCLES(TICK),
        .MIN_TICKS(MIN_T),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .pwm_in(pwm_in),
        .duty_out(duty_out),
        .duty_valid(duty_valid),
        .duty_sat(duty_sat),
        .signal_lost(signal_lost)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (duty_valid === 1'b1) begin
            strobe_cnt = strobe_cnt + 1;
            last_strobe_cyc = cyc;
        end
    end

    // All drive tasks start and end on a falling clock edge.
    task automatic hold(input logic v, input int n);
        pwm_in = v;
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse(input int high_cycles, input int low_after);
        hold(1'b1, high_cycles);
        fall_cyc = cyc;
        hold(1'b0, low_after);
    endtask

    task automatic test_reset();
        int s0;
        s0 = strobe_cnt;
        reset  = 1'b1;
        pwm_in = 1'b0;
        repeat (4) @(negedge clock);
        total++; if (duty_out !== 10'd0) begin bad++; $display("FAIL reset_duty: got %0d want 0", duty_out); end
        total++; if (duty_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", duty_valid); end
        total++; if (duty_sat !== 1'b0) begin bad++; $display("FAIL reset_sat: got %b want 0", duty_sat); end
        total++; if (signal_lost !== 1'b1) begin bad++; $display("FAIL reset_lost: got %b want 1", signal_lost); end
        reset = 1'b0;
        @(negedge clock);
        total++; if (strobe_cnt != s0) begin bad++; $display("FAIL reset_strobe: got %0d want 0", strobe_cnt - s0); end
    endtask

    task automatic test_basic();
        int s0;
        hold(1'b0, 1000);
        s0 = strobe_cnt;
        pulse(3000, 20);
        total++; if (strobe_cnt - s0 != 1) begin bad++; $display("FAIL basic_strobes: got %0d want 1", strobe_cnt - s0); end
        total++; if (last_strobe_cyc != fall_cyc + 4) begin bad++; $display("FAIL basic_latency: got cycle %0d want %0d", last_strobe_cyc, fall_cyc + 4); end
        total++; if (duty_out !== 10'd750) begin bad++; $display("FAIL basic_duty: got %0d want 750", duty_out); end
        total++; if (duty_sat !== 1'b0) begin bad++; $display("FAIL basic_sat: got %b want 0", duty_sat); end
        total++; if (signal_lost !== 1'b0) begin bad++; $display("FAIL basic_lost: got %b want 0", signal_lost); end
    endtask

    task automatic test_saturation();
        int s0;
        s0 = strobe_cnt;
        pulse(5000, 20);
        total++; if (duty_out !== 10'd1023) begin bad++; $display("FAIL sat_duty: got %0d want 1023", duty_out); end
        total++; if (duty_sat !== 1'b1) begin bad++; $display("FAIL sat_flag: got %b want 1", duty_sat); end
        pulse(2000, 20);
        total++; if (duty_out !== 10'd500) begin bad++; $display("FAIL sat_next_duty: got %0d want 500", duty_out); end
        total++; if (duty_sat !== 1'b0) begin bad++; $display("FAIL sat_next_flag: got %b want 0", duty_sat); end
        total++; if (strobe_cnt - s0 != 2) begin bad++; $display("FAIL sat_strobes: got %0d want 2", strobe_cnt - s0); end
    endtask

    task automatic test_short_pulse();
        int s0;
        pulse(3000, 20);
        s0 = strobe_cnt;
        pulse(12, 40);
        total++; if (strobe_cnt != s0) begin bad++; $display("FAIL short_strobe: got %0d want 0", strobe_cnt - s0); end
        total++; if (duty_out !== 10'd750) begin bad++; $display("FAIL short_duty: got %0d want 750", duty_out); end
    endtask

    task automatic test_boundary();
        int s0;
        s0 = strobe_cnt;
        pulse(31, 40);
        total++; if (strobe_cnt != s0) begin bad++; $display("FAIL bound_7_strobe: got %0d want 0", strobe_cnt - s0); end
        total++; if (duty_out !== 10'd750) begin bad++; $display("FAIL bound_7_duty: got %0d want 750", duty_out); end
        pulse(32, 20);
        total++; if (strobe_cnt - s0 != 1) begin bad++; $display("FAIL bound_8_strobe: got %0d want 1", strobe_cnt - s0); end
        total++; if (duty_out !== 10'd8) begin bad++; $display("FAIL bound_8_duty: got %0d want 8", duty_out); end
    endtask

    task automatic test_timeout();
        int s0;
        s0 = strobe_cnt;
        hold(1'b0, 6900);
        total++; if (signal_lost !== 1'b0) begin bad++; $display("FAIL tmo_early_lost: got %b want 0", signal_lost); end
        hold(1'b0, 1200);
        total++; if (signal_lost !== 1'b1) begin bad++; $display("FAIL tmo_lost: got %b want 1", signal_lost); end
        total++; if (duty_out !== 10'd8) begin bad++; $display("FAIL tmo_hold_duty: got %0d want 8", duty_out); end
        pulse(2400, 20);
        total++; if (duty_out !== 10'd600) begin bad++; $display("FAIL tmo_recover_duty: got %0d want 600", duty_out); end
        total++; if (signal_lost !== 1'b0) begin bad++; $display("FAIL tmo_recover_lost: got %b want 0", signal_lost); end
        total++; if (strobe_cnt - s0 != 1) begin bad++; $display("FAIL tmo_strobes: got %0d want 1", strobe_cnt - s0); end
    endtask

    task automatic test_high_at_reset();
        int s0;
        s0 = strobe_cnt;
        pwm_in = 1'b1;
        reset  = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        hold(1'b1, 8100);
        total++; if (strobe_cnt != s0) begin bad++; $display("FAIL hir_strobe: got %0d want 0", strobe_cnt - s0); end
        total++; if (signal_lost !== 1'b1) begin bad++; $display("FAIL hir_lost: got %b want 1", signal_lost); end
        total++; if (duty_out !== 10'd0) begin bad++; $display("FAIL hir_duty0: got %0d want 0", duty_out); end
        hold(1'b0, 50);
        total++; if (strobe_cnt != s0) begin bad++; $display("FAIL hir_drop_strobe: got %0d want 0", strobe_cnt - s0); end
        pulse(3000, 20);
        total++; if (duty_out !== 10'd750) begin bad++; $display("FAIL hir_duty: got %0d want 750", duty_out); end
        total++; if (strobe_cnt - s0 != 1) begin bad++; $display("FAIL hir_strobes: got %0d want 1", strobe_cnt - s0); end
    endtask

    task automatic test_reset_mid_pulse();
        int s0;
        hold(1'b0, 50);
        s0 = strobe_cnt;
        hold(1'b1, 1500);
        reset = 1'b1;
        hold(1'b1, 3);
        reset = 1'b0;
        hold(1'b1, 1500);
        hold(1'b0, 50);
        total++; if (strobe_cnt != s0) begin bad++; $display("FAIL rmp_strobe: got %0d want 0", strobe_cnt - s0); end
        total++; if (duty_out !== 10'd0) begin bad++; $display("FAIL rmp_duty: got %0d want 0", duty_out); end
        pulse(3000, 20);
        total++; if (duty_out !== 10'd750) begin bad++; $display("FAIL rmp_next_duty: got %0d want 750", duty_out); end
        total++; if (strobe_cnt - s0 != 1) begin bad++; $display("FAIL rmp_strobes: got %0d want 1", strobe_cnt - s0); end
    endtask

    initial begin
        reset  = 1'b1;
        pwm_in = 1'b0;
        @(negedge clock);
        test_reset();
        test_basic();
        test_saturation();
        test_short_pulse();
        test_boundary();
        test_timeout();
        test_high_at_reset();
        test_reset_mid_pulse();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
